// File: rtl/spbram_arbiter_if.sv
// Requester-side bus of the shared single-port RAM arbiter.
// Flattened per-requester fields: requester i owns addr[i*AW +: AW] and wdata[i*DW +: DW].
interface spbram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               busy;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/spbram_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port RAM among NREQ requesters.
// Optional post-reset zero sweep of the RAM is enabled by defining SPBRAM_ARB_CLEAR_EN.
module spbram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    spbram_arbiter_if.slave       bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic            w_clr;
    logic [AW-1:0]   w_clr_addr;

`ifdef SPBRAM_ARB_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_addr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_addr == {AW{1'b1}})
            w_state_nxt = S_RUN;
    end

    assign w_clr      = (r_state == S_CLEAR);
    assign w_clr_addr = r_clr_addr;
`else
    assign w_clr      = 1'b0;
    assign w_clr_addr = '0;
`endif

    // Scan from rr_ptr upward, wrapping at NREQ-1, first request wins.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!w_found && bus.req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : PW'(w_win + 1'b1);

    // Reset gates every RAM/grant output, so nothing can be accepted under reset.
    always_comb begin
        w_gnt    = '0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (reset_n) begin
            if (w_clr) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = w_clr_addr;
            end else if (w_found) begin
                w_gnt[w_win] = 1'b1;
                ram_en       = 1'b1;
                ram_we       = bus.we[w_win];
                ram_addr     = bus.addr[int'(w_win)*AW +: AW];
                ram_din      = bus.wdata[int'(w_win)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt & ~bus.we;
            if (|w_gnt)
                r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Gating with reset_n drops a pending rvalid in the very cycle reset arrives.
    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid & {NREQ{reset_n}};
    assign bus.rdata  = ram_dout;
    assign bus.busy   = w_clr;
endmodule

// File: tb/tb_spbram_arbiter.sv
// Directed bench for spbram_arbiter: per-cycle vector table plus fairness and clear sequences.
module tb_spbram_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic          pl_en, pl_fill;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    spbram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    spbram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock    (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM with registered output, plus a bench preload path.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
        if (pl_en)
            mem[pl_addr] <= pl_data;
        if (pl_fill)
            for (int i = 0; i < 1024; i++)
                mem[i] <= 32'hFFFF_FFFF;
    end

    typedef struct {
        logic                 rst;
        logic [3:0]           req;
        logic [3:0]           we;
        logic [3:0][AW-1:0]   addr;
        logic [3:0][DW-1:0]   wdata;
        logic [3:0]           eg;
        logic                 ewe;
        logic [3:0]           erv;
        logic                 ck;
        logic [DW-1:0]        erd;
        logic [AW-1:0]        ea;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] we,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [3:0] eg, input logic ewe, input logic [3:0] erv,
                                input logic ck, input logic [DW-1:0] erd);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we;
        v.eg = eg; v.ewe = ewe; v.erv = erv; v.ck = ck; v.erd = erd;
        v.ea = a;
        for (int i = 0; i < 4; i++) begin
            v.addr[i]  = a + AW'(i);
            v.wdata[i] = d + DW'(i);
            if (eg[i])
                v.ea = a + AW'(i);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
`ifdef SPBRAM_ARB_CLEAR_EN
        bit done;
        done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.req = '0;
        for (int k = 0; k < 2000; k++) begin
            #2;
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("clear_done", {31'd0, done}, 32'd1);
`endif
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset_n   = !v.rst;
        bus.req   = v.req;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        #2;
        chk($sformatf("v%0d gnt", idx), {28'd0, bus.gnt}, {28'd0, v.eg});
        chk($sformatf("v%0d ram_en", idx), {31'd0, ram_en}, {31'd0, |v.eg});
        chk($sformatf("v%0d rvalid", idx), {28'd0, bus.rvalid}, {28'd0, v.erv});
        chk($sformatf("v%0d busy", idx), {31'd0, bus.busy}, 32'd0);
        if (|v.eg) begin
            chk($sformatf("v%0d ram_we", idx), {31'd0, ram_we}, {31'd0, v.ewe});
            chk($sformatf("v%0d ram_addr", idx), {22'd0, ram_addr}, {22'd0, v.ea});
        end
        if (v.ck)
            chk($sformatf("v%0d rdata", idx), bus.rdata, v.erd);
    endtask

    initial begin
        int last [4];
        int cnt;
        bit nog;

        reset_n = 1'b0; pl_en = 1'b0; pl_fill = 1'b0; pl_addr = '0; pl_data = '0;
        bus.req = 4'hF; bus.we = '0; bus.addr = '0; bus.wdata = '0;

        // Reset state: requests present but nothing granted or enabled.
        @(negedge clk); @(negedge clk); #2;
        chk("rst gnt", {28'd0, bus.gnt}, 32'd0);
        chk("rst ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst rvalid", {28'd0, bus.rvalid}, 32'd0);
        bus.req = '0;
        wait_ready();

        @(negedge clk);
        reset_n = 1'b1; pl_en = 1'b1; pl_addr = 10'h155; pl_data = 32'hDEAD_BEEF;
        @(negedge clk);
        pl_en = 1'b0;

        // Single read, write-then-read, reset, full rotation, alternation, reset after read.
        vt.push_back(mk(0, 4'b0100, 4'b0000, 10'h153, 32'h0, 4'b0100, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b0100, 1, 32'hDEAD_BEEF));
        vt.push_back(mk(0, 4'b0001, 4'b0001, 10'h3FF, 32'h1234_5678, 4'b0001, 1, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0001, 4'b0000, 10'h3FF, 32'h0, 4'b0001, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b0001, 1, 32'h1234_5678));
        vt.push_back(mk(1, 4'b1111, 4'b0000, 10'h100, 32'h0, 4'b0000, 0, 4'b0000, 0, 32'h0));
        for (int k = 0; k < 8; k++)
            vt.push_back(mk(0, 4'b1111, 4'b0000, 10'h100, 32'h0, 4'(1 << (k % 4)), 0,
                            (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)), 0, 32'h0));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b1000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0010, 4'b0000, 10'h000, 32'h0, 4'b0010, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b1010, 4'b0000, 10'h000, 32'h0, 4'b1000, 0, 4'b0010, 0, 32'h0));
        vt.push_back(mk(0, 4'b1010, 4'b0000, 10'h000, 32'h0, 4'b0010, 0, 4'b1000, 0, 32'h0));
        vt.push_back(mk(0, 4'b1010, 4'b0000, 10'h000, 32'h0, 4'b1000, 0, 4'b0010, 0, 32'h0));
        vt.push_back(mk(0, 4'b1010, 4'b0000, 10'h000, 32'h0, 4'b0010, 0, 4'b1000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b0010, 0, 32'h0));
        vt.push_back(mk(0, 4'b0100, 4'b0000, 10'h153, 32'h0, 4'b0100, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b1100, 4'b0000, 10'h153, 32'h0, 4'b0100, 0, 4'b0000, 0, 32'h0));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 10'h000, 32'h0, 4'b0000, 0, 4'b0100, 1, 32'hDEAD_BEEF));

        foreach (vt[i]) begin
            apply(vt[i], i);
            if (vt[i].rst)
                wait_ready();
        end

        // Fairness: all four held; one-hot grants and no requester waits more than NREQ-1 cycles.
        foreach (last[i]) last[i] = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.req = 4'hF; bus.we = 4'h0;
            #2;
            chk($sformatf("fair c%0d onehot", c), $countones(bus.gnt), 32'd1);
            for (int r = 0; r < 4; r++) begin
                if (bus.gnt[r]) begin
                    if (last[r] >= 0)
                        chk($sformatf("fair c%0d gap r%0d", c, r), c - last[r], 32'd4);
                    last[r] = c;
                end
            end
        end
        @(negedge clk);
        bus.req = '0;

`ifdef SPBRAM_ARB_CLEAR_EN
        // Clear sweep: RAM filled with ones, reset, held read of 0x200 waits out 1024 busy cycles.
        @(negedge clk);
        pl_fill = 1'b1;
        @(negedge clk);
        pl_fill   = 1'b0;
        reset_n   = 1'b0;
        bus.req   = 4'b0001;
        bus.we    = 4'b0000;
        bus.addr  = {10'h0, 10'h0, 10'h0, 10'h200};
        cnt = 0; nog = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            #2;
            if (!bus.busy)
                break;
            cnt++;
            if (bus.gnt != 4'b0000)
                nog = 1'b0;
            @(negedge clk);
        end
        chk("clr busy cycles", cnt, 32'd1024);
        chk("clr no gnt", {31'd0, nog}, 32'd1);
        chk("clr first gnt", {28'd0, bus.gnt}, 32'd1);
        @(negedge clk);
        bus.req = '0;
        #2;
        chk("clr rvalid", {28'd0, bus.rvalid}, 32'd1);
        chk("clr rdata", bus.rdata, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
